// File: rtl/ppu_pixel_packer_if.sv
// Pixel-stream input and framebuffer write bus of the PPU pixel packer.
// master drives pixels/PPU status and fb_ready; slave is the packer.
interface ppu_pixel_packer_if;
  logic [1:0]  px_in;
  logic        px_valid;
  logic [1:0]  ppu_mode;
  logic [7:0]  ly;
  logic [7:0]  bgp;
  logic        fb_wr_en;
  logic [12:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ready;
  logic        line_done;
  logic        frame_start;
  logic        overflow;

  modport master (
    output px_in, px_valid, ppu_mode, ly, bgp, fb_ready,
    input  fb_wr_en, fb_addr, fb_data, line_done, frame_start, overflow
  );

  modport slave (
    input  px_in, px_valid, ppu_mode, ly, bgp, fb_ready,
    output fb_wr_en, fb_addr, fb_data, line_done, frame_start, overflow
  );
endinterface

// File: rtl/ppu_pixel_packer.sv
// Packs the 2-bit background pixel stream 4-per-byte into a write FIFO for the framebuffer.
// Define PXP_PALETTE_EN to map pixels through BGP; otherwise raw colour indices are packed.
module ppu_pixel_packer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int LINE_PIXELS = 160,
  parameter int LINE_BYTES  = 40
) (
  input logic               clk,
  input logic               rst,
  ppu_pixel_packer_if.slave bus
);

  localparam int           AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]   LINE_PX    = 8'(LINE_PIXELS);
  localparam logic [5:0]   LAST_GROUP = 6'(LINE_BYTES - 1);
  localparam logic [1:0]   MODE_VBL   = 2'd1;
  localparam logic [1:0]   MODE_DRAW  = 2'd3;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, VBL} state_t;

  state_t          state, state_nxt;
  logic [7:0]      x;
  logic [1:0]      pack_cnt;
  logic [5:0]      pack_reg;
  logic            armed;
  logic            frame_start_q;
  logic            overflow_q;

  logic [12:0]     mem_addr [FIFO_DEPTH];
  logic [7:0]      mem_data [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  logic [1:0]      shade;
  logic            take_px, visible, full, pop, push_req, push_ok, line_done_c;
  logic [12:0]     push_addr;
  logic [7:0]      full_byte, partial_byte, push_data;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (bus.ppu_mode == MODE_VBL) state_nxt = VBL;
    else begin
      case (state)
        IDLE:    if (bus.ppu_mode == MODE_DRAW && armed) state_nxt = ACTIVE;
        ACTIVE:  if (bus.ppu_mode != MODE_DRAW) state_nxt = FLUSH;
        FLUSH:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef PXP_PALETTE_EN
  always_comb begin
    shade = 2'd0;
    case (bus.px_in)
      2'd0: shade = bus.bgp[1:0];
      2'd1: shade = bus.bgp[3:2];
      2'd2: shade = bus.bgp[5:4];
      2'd3: shade = bus.bgp[7:6];
    endcase
  end
`else
  logic unused_bgp;
  assign unused_bgp = ^bus.bgp;
  assign shade      = bus.px_in;
`endif

  assign take_px   = (state == ACTIVE) && bus.px_valid && (x < LINE_PX);
  assign visible   = bus.ly < 8'd144;
  assign push_addr = {bus.ly, 5'b0} + {2'b0, bus.ly, 3'b0} + {7'b0, x[7:2]};
  assign full_byte = {pack_reg, shade};

  // Partial groups stay left-justified: earliest pixel always lands in [7:6].
  always_comb begin
    partial_byte = 8'h00;
    case (pack_cnt)
      2'd1:    partial_byte = {pack_reg[1:0], 6'b0};
      2'd2:    partial_byte = {pack_reg[3:0], 4'b0};
      2'd3:    partial_byte = {pack_reg[5:0], 2'b0};
      default: partial_byte = 8'h00;
    endcase
  end

  always_comb begin
    push_req    = 1'b0;
    push_data   = full_byte;
    line_done_c = 1'b0;
    if (take_px && pack_cnt == 2'd3 && visible) begin
      push_req    = 1'b1;
      line_done_c = (x[7:2] == LAST_GROUP);
    end else if (state == FLUSH && pack_cnt != 2'd0 && visible) begin
      push_req    = 1'b1;
      push_data   = partial_byte;
      line_done_c = 1'b1;
    end
  end

  assign full    = (count == DEPTH_C);
  assign pop     = bus.fb_wr_en && bus.fb_ready;
  assign push_ok = push_req && (!full || pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      x             <= 8'd0;
      pack_cnt      <= 2'd0;
      pack_reg      <= 6'd0;
      armed         <= 1'b0;
      frame_start_q <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      state         <= state_nxt;
      armed         <= armed | (bus.ppu_mode != MODE_DRAW);
      frame_start_q <= (state_nxt == VBL) && (state != VBL);
      if (take_px) begin
        pack_reg <= full_byte[5:0];
        pack_cnt <= pack_cnt + 2'd1;
        x        <= x + 8'd1;
      end
      if (state == FLUSH || state == VBL) begin
        x        <= 8'd0;
        pack_cnt <= 2'd0;
      end
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow_q <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; count/pointers alone decide validity and outputs are gated when empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  assign bus.fb_wr_en    = (count != '0);
  assign bus.fb_addr     = bus.fb_wr_en ? mem_addr[rd_ptr] : 13'd0;
  assign bus.fb_data     = bus.fb_wr_en ? mem_data[rd_ptr] : 8'd0;
  assign bus.line_done   = line_done_c;
  assign bus.frame_start = frame_start_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_ppu_pixel_packer.sv
// Directed bench for ppu_pixel_packer; framebuffer writes are captured on the falling edge and
// compared against hand-computed address/data lists.
module tb_ppu_pixel_packer;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  ppu_pixel_packer_if bus ();

  ppu_pixel_packer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  wr_t writes[$];
  int  line_done_cnt   = 0;
  int  frame_start_cnt = 0;
  int  n_checks        = 0;
  int  n_pass          = 0;

  // Handshake values are stable at the falling edge and get consumed at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.fb_wr_en && bus.fb_ready) writes.push_back({bus.fb_addr, bus.fb_data});
      if (bus.line_done)   line_done_cnt++;
      if (bus.frame_start) frame_start_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    writes.delete();
    line_done_cnt = 0;
  endtask

  task automatic begin_line(input logic [7:0] ly, input logic [7:0] bgp);
    tick();
    bus.ly       = ly;
    bus.bgp      = bgp;
    bus.ppu_mode = 2'd3;
    bus.px_valid = 1'b0;
  endtask

  task automatic send_px(input logic [1:0] p);
    tick();
    bus.px_valid = 1'b1;
    bus.px_in    = p;
  endtask

  task automatic end_line();
    tick();
    bus.px_valid = 1'b0;
    bus.ppu_mode = 2'd0;
    repeat (10) tick();
  endtask

  task automatic check_line(input string tag, input int base, input int n, input logic [7:0] data);
    check({tag, ".count"}, writes.size(), n);
    for (int i = 0; i < n && i < writes.size(); i++) begin
      check($sformatf("%s.addr%0d", tag, i), 32'(writes[i].addr), base + i);
      check($sformatf("%s.data%0d", tag, i), 32'(writes[i].data), 32'(data));
    end
  endtask

  logic [7:0] exp_t2;

  initial begin
`ifdef PXP_PALETTE_EN
    exp_t2 = 8'hE4;
`else
    exp_t2 = 8'h1B;
`endif
    bus.px_in    = 2'd0;
    bus.px_valid = 1'b0;
    bus.ppu_mode = 2'd0;
    bus.ly       = 8'd0;
    bus.bgp      = 8'hE4;
    bus.fb_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    rst = 1'b1;
    check("reset.fb_wr_en",    bus.fb_wr_en,    0);
    check("reset.fb_addr",     bus.fb_addr,     0);
    check("reset.fb_data",     bus.fb_data,     0);
    check("reset.line_done",   bus.line_done,   0);
    check("reset.frame_start", bus.frame_start, 0);
    check("reset.overflow",    bus.overflow,    0);
    repeat (2) tick();

    // 1: full line of colour 1, identity palette
    clear_log();
    begin_line(8'd0, 8'hE4);
    for (int i = 0; i < 160; i++) send_px(2'd1);
    end_line();
    check_line("t1", 0, 40, 8'h55);
    check("t1.line_done", line_done_cnt, 1);

    // 2: last visible line, reversing palette, pattern 0,1,2,3
    clear_log();
    begin_line(8'd143, 8'h1B);
    for (int i = 0; i < 160; i++) send_px(2'(i % 4));
    end_line();
    check_line("t2", 5720, 40, exp_t2);
    check("t2.line_done", line_done_cnt, 1);

    // 4: partial group flushed on leaving DRAW
    clear_log();
    begin_line(8'd5, 8'hE4);
    send_px(2'd3); send_px(2'd3); send_px(2'd3); send_px(2'd3);
    send_px(2'd2); send_px(2'd1);
    end_line();
    check("t4.count", writes.size(), 2);
    if (writes.size() == 2) begin
      check("t4.addr0", 32'(writes[0].addr), 200);
      check("t4.data0", 32'(writes[0].data), 32'h0FF);
      check("t4.addr1", 32'(writes[1].addr), 201);
      check("t4.data1", 32'(writes[1].data), 32'h090);
    end
    check("t4.line_done", line_done_cnt, 1);

    // 5: 170 pixels, extra ten dropped; next line restarts at x=0
    clear_log();
    begin_line(8'd10, 8'hE4);
    for (int i = 0; i < 170; i++) send_px(2'(i % 4));
    end_line();
    check_line("t5", 400, 40, 8'h1B);
    check("t5.line_done", line_done_cnt, 1);
    clear_log();
    begin_line(8'd11, 8'hE4);
    for (int i = 0; i < 4; i++) send_px(2'd2);
    end_line();
    check_line("t5.next", 440, 1, 8'hAA);
    check("t5.next.line_done", line_done_cnt, 0);

    // V_BLANK entry pulse
    tick();
    bus.ppu_mode = 2'd1;
    repeat (5) tick();
    check("vbl.frame_start", frame_start_cnt, 1);
    bus.ppu_mode = 2'd0;
    repeat (3) tick();

    // 3: stalled framebuffer, fifth push overflows
    clear_log();
    bus.fb_ready = 1'b0;
    begin_line(8'd2, 8'hE4);
    for (int i = 0; i < 20; i++) send_px(2'd3);
    end_line();
    check("t3.overflow",   bus.overflow,  1);
    check("t3.stall.cnt", writes.size(), 0);
    check("t3.hold.en",   bus.fb_wr_en,  1);
    check("t3.hold.addr", bus.fb_addr,   80);
    check("t3.hold.data", bus.fb_data,   32'h0FF);
    bus.fb_ready = 1'b1;
    repeat (8) tick();
    check_line("t3", 80, 4, 8'hFF);
    check("t3.line_done", line_done_cnt, 0);
    check("t3.sticky", bus.overflow, 1);

    // 6: reset mid-line discards queued writes; resume only at next DRAW entry
    clear_log();
    bus.fb_ready = 1'b0;
    begin_line(8'd7, 8'hE4);
    for (int i = 0; i < 10; i++) send_px(2'd3);
    tick();
    bus.px_valid = 1'b0;
    check("t6.pre.en", bus.fb_wr_en, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t6.fb_wr_en", bus.fb_wr_en, 0);
    check("t6.overflow", bus.overflow, 0);
    bus.fb_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_px(2'd3);
    end_line();
    check("t6.nowrites", writes.size(), 0);
    clear_log();
    begin_line(8'd8, 8'hE4);
    for (int i = 0; i < 4; i++) send_px(2'd1);
    end_line();
    check_line("t6.next", 320, 1, 8'h55);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
